// File: rtl/alt_vipitc130_common_mode_select.sv
// Mode selector: one-hot match -> binary mode, debounced, committed at start-of-frame.
// Optional multi-hot rejection and sticky error flag: define MODE_SELECT_MULTI_HOT_CHECK_EN.
module alt_vipitc130_common_mode_select #(
  parameter int unsigned NO_OF_MODES      = 3,
  parameter int unsigned LOG2_NO_OF_MODES = 2,
  parameter int unsigned STABLE_COUNT     = 4,
  parameter int unsigned STABLE_CNT_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        match_valid,
  input  logic [NO_OF_MODES-1:0]      match,
  input  logic                        sof,
  output logic [LOG2_NO_OF_MODES-1:0] mode,
  output logic                        mode_change_valid,
  input  logic                        mode_change_ack,
  output logic                        locked,
  output logic                        multi_hot_err
);

  typedef enum logic [1:0] {StLocked, StWaitSof, StNotify} state_e;

  localparam logic [STABLE_CNT_WIDTH-1:0] CntMax = STABLE_CNT_WIDTH'(STABLE_COUNT);

  state_e                      state_q, state_d;
  logic [LOG2_NO_OF_MODES-1:0] enc;
  logic [LOG2_NO_OF_MODES-1:0] cand_q;
  logic                        cand_v;
  logic                        sample_ok;
  logic [LOG2_NO_OF_MODES-1:0] pending_q, pending_d;
  logic [STABLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        cand_diff;
  logic                        stable;
  logic [LOG2_NO_OF_MODES-1:0] mode_q, mode_d;
  logic                        valid_q, valid_d;
  logic                        locked_q, locked_d;

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    enc = '0;
    for (int i = int'(NO_OF_MODES) - 1; i >= 0; i--) begin
      if (match[i]) enc = LOG2_NO_OF_MODES'(i + 1);
    end
  end

`ifdef MODE_SELECT_MULTI_HOT_CHECK_EN
  logic multi_hot;
  logic err_q;

  assign multi_hot = |(match & (match - NO_OF_MODES'(1)));
  assign sample_ok = match_valid & ~multi_hot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (match_valid && multi_hot) begin
      err_q <= 1'b1;
    end
  end

  assign multi_hot_err = err_q;
`else
  assign sample_ok     = match_valid;
  assign multi_hot_err = 1'b0;
`endif

  // Stage 1: registered encode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cand_v <= 1'b0;
    end else begin
      cand_v <= sample_ok;
      if (sample_ok) cand_q <= enc;
    end
  end

  // Stage 2: run-length tracking of the candidate, saturating at CntMax
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    cand_diff = cand_v && (cand_q != pending_q);
    if (cand_v) begin
      if (cand_diff) begin
        pending_d = cand_q;
        cnt_d     = STABLE_CNT_WIDTH'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + STABLE_CNT_WIDTH'(1);
      end
    end
    stable = (cnt_d == CntMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLocked;
      mode_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLocked:  if (stable && (pending_d != mode_q)) state_d = StWaitSof;
      StWaitSof: begin
        if (cand_diff) state_d = StLocked;
        else if (sof)  state_d = StNotify;
      end
      StNotify:  if (mode_change_ack) state_d = StLocked;
      default:   state_d = StLocked;
    endcase
  end

  // Pending cannot move while committing: any differing sample leaves StWaitSof instead.
  always_comb begin
    mode_d   = mode_q;
    valid_d  = valid_q;
    locked_d = (state_q == StLocked) && (cnt_q == CntMax) && (pending_q == mode_q);
    if (state_q == StWaitSof && state_d == StNotify) begin
      mode_d  = pending_q;
      valid_d = 1'b1;
    end else if (state_q == StNotify && state_d == StLocked) begin
      valid_d = 1'b0;
    end
  end

  assign mode              = mode_q;
  assign mode_change_valid = valid_q;
  assign locked            = locked_q;

endmodule

// File: tb/tb_alt_vipitc130_common_mode_select.sv
// Scoreboard bench for alt_vipitc130_common_mode_select: directed scenarios plus random stimulus
// against a sample-history reference model.
module tb_alt_vipitc130_common_mode_select;

  localparam int N  = 3;
  localparam int L  = 2;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         match_valid = 1'b0;
  logic [N-1:0] match = '0;
  logic         sof = 1'b0;
  logic         mode_change_ack = 1'b0;
  logic [L-1:0] mode;
  logic         mode_change_valid;
  logic         locked;
  logic         multi_hot_err;

  alt_vipitc130_common_mode_select #(
    .NO_OF_MODES(N), .LOG2_NO_OF_MODES(L), .STABLE_COUNT(SC), .STABLE_CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .match_valid(match_valid), .match(match), .sof(sof),
    .mode(mode), .mode_change_valid(mode_change_valid), .mode_change_ack(mode_change_ack),
    .locked(locked), .multi_hot_err(multi_hot_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: history of accepted samples, a one-deep encode pipe and a phase.
  int samp_q[$];
  int exp_q[$];
  bit s1_v;
  int s1_val;
  int phase;   // 0 idle/locked, 1 waiting for sof, 2 notifying
  int m_mode;
  bit m_valid, m_locked, m_err;

  function automatic int enc_ref(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i + 1;
    return 0;
  endfunction

  function automatic int pend_ref();
    return (samp_q.size() == 0) ? 0 : samp_q[samp_q.size()-1];
  endfunction

  function automatic int run_ref();
    int r = 0;
    for (int i = samp_q.size() - 1; i >= 0; i--) begin
      if (samp_q[i] != samp_q[samp_q.size()-1] || r == SC) break;
      r++;
    end
    return r;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    s1_v = 0; s1_val = 0; phase = 0;
    m_mode = 0; m_valid = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_step(input bit mv, input logic [N-1:0] m, input bit s, input bit a);
    int  p0, r0, p1, r1;
    bit  chg, lock_n, multi;
    p0     = pend_ref();
    r0     = run_ref();
    lock_n = (phase == 0) && (r0 == SC) && (p0 == m_mode);
    chg    = s1_v && (s1_val != p0);
    if (s1_v) begin
      samp_q.push_back(s1_val);
      if (samp_q.size() > SC) void'(samp_q.pop_front());
    end
    p1 = pend_ref();
    r1 = run_ref();
    case (phase)
      0: if (r1 == SC && p1 != m_mode) phase = 1;
      1: begin
        if (chg) phase = 0;
        else if (s) begin
          m_mode = p0; m_valid = 1; exp_q.push_back(p0); phase = 2;
        end
      end
      default: if (a) begin m_valid = 0; phase = 0; end
    endcase
    m_locked = lock_n;
    multi = ($countones(m) > 1);
    if (mv) begin
`ifdef MODE_SELECT_MULTI_HOT_CHECK_EN
      if (multi) m_err = 1;
      s1_v = !multi;
`else
      s1_v = 1;
`endif
      s1_val = enc_ref(m);
    end else begin
      s1_v = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit mv, input logic [N-1:0] m, input bit s,
                     input bit a);
    @(negedge clk);
    #1;
    rst = r; match_valid = mv; match = m; sof = s; mode_change_ack = a;
    if (r) model_reset();
    else model_step(mv, m, s, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0);
  endtask

  task automatic samples(input logic [N-1:0] m, input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, m, 0, 0);
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on each new commit.
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", int'(mode_change_valid), int'(m_valid));
      chk("mode", int'(mode), m_mode);
      chk("locked", int'(locked), int'(m_locked));
      chk("multi_hot_err", int'(multi_hot_err), int'(m_err));
      if (mode_change_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_commit", 1, 0);
        else chk("commit_mode", int'(mode), exp_q.pop_front());
      end
    end
    prev_valid = mode_change_valid;
  end

  initial begin
    logic [N-1:0] vals [7];
    logic [N-1:0] v;
    int           len;
    vals = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b011};
    model_reset();
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);

    // Basic commit of mode 2, then ack
    samples(3'b010, 4);
    idle(2);
    cyc(0, 0, '0, 1, 0);
    idle(2);
    cyc(0, 0, '0, 0, 1);
    idle(3);
    chk("basic_mode", int'(mode), 2);
    chk("basic_locked", int'(locked), 1);

    // Interrupted run never stabilises; sof must not commit
    samples(3'b100, 3);
    samples(3'b001, 1);
    cyc(0, 0, '0, 1, 0);
    idle(3);
    chk("short_run_mode", int'(mode), 2);

    // Waiting for sof, then a differing sample, then a full run of mode 1
    samples(3'b100, 4);
    idle(2);
    samples(3'b001, 4);
    idle(2);
    cyc(0, 0, '0, 1, 0);
    idle(1);
    chk("abort_then_mode1", int'(mode), 1);

    // Held in notify: sofs and a new stable input are ignored until ack
    for (int i = 0; i < 5; i++) cyc(0, 1, 3'b100, 1, 0);
    idle(2);
    chk("notify_hold_valid", int'(mode_change_valid), 1);
    cyc(0, 0, '0, 1, 1);
    idle(2);
    cyc(0, 0, '0, 1, 0);
    idle(1);
    chk("after_ack_mode3", int'(mode), 3);
    cyc(0, 0, '0, 0, 1);
    idle(2);

    // Multi-hot sample
    cyc(0, 1, 3'b011, 0, 0);
    idle(3);

    // Random stimulus: runs of a value with gaps, random sof and ack
    for (int s = 0; s < 80; s++) begin
      v   = vals[$urandom_range(0, 6)];
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        cyc(0, ($urandom % 4) != 0, v, ($urandom % 6) == 0, ($urandom % 3) == 0);
    end

    // Async reset mid-handshake with mode 3
    cyc(0, 0, '0, 0, 1);
    idle(2);
    samples(3'b100, 4);
    idle(2);
    cyc(0, 0, '0, 1, 0);
    idle(2);
    chk("pre_reset_valid", int'(mode_change_valid), 1);
    chk("pre_reset_mode", int'(mode), 3);
    #2;
    rst = 1;
    model_reset();
    exp_q.delete();
    #1;
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_valid", int'(mode_change_valid), 0);
    chk("async_rst_locked", int'(locked), 0);
    cyc(1, 0, '0, 0, 0);
    idle(3);

    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
